axi4_burst_master: RTL and testbench
====================================

// Module: axi4_burst_master
// PURPOSE
//  AXI4 full-protocol master: the initiator end of the AXI4 slave bus used by the FHE data-path wrappers.
//  Turns one local command (read or write, base address, burst length) into a single INCR burst.
//  Write data comes from a local valid/ready stream; read data leaves on a local valid/ready stream.
//  One transaction in flight; testbench/DMA engine drives the command port.
// PARAMETERS
//  C_M_AXI_ID_WIDTH    1    AWID/ARID width; IDs are driven to 0
//  C_M_AXI_DATA_WIDTH  512  data bus width; AxSIZE = log2(C_M_AXI_DATA_WIDTH/8)
//  C_M_AXI_ADDR_WIDTH  32   byte address width
// PORTS
//  m00_axi_aclk     in   1    single clock
//  m00_axi_aresetn  in   1    asynchronous active-low reset
//  cmd_valid        in   1    command request
//  cmd_ready        out  1    high only in IDLE
//  cmd_rnw          in   1    1=read burst, 0=write burst
//  cmd_addr         in   ADDR byte address; must be beat-aligned
//  cmd_len          in   8    beats-1 (AxLEN)
//  wr_data/wr_valid/wr_ready  in/in/out  DATA/1/1  write payload stream
//  rd_data/rd_valid/rd_ready/rd_last  out/out/in/out  DATA/1/1/1  read payload stream
//  done             out  1    one-cycle pulse at transaction end
//  err              out  1    valid with done; 1 = any BRESP/RRESP != OKAY (or rejected cmd)
//  m00_axi_aw*: awid,awaddr,awlen,awsize,awburst,awvalid out; awready in
//  m00_axi_w*:  wdata,wstrb,wlast,wvalid out; wready in
//  m00_axi_b*:  bid,bresp,bvalid in; bready out
//  m00_axi_ar*: arid,araddr,arlen,arsize,arburst,arvalid out; arready in
//  m00_axi_r*:  rid,rdata,rresp,rlast,rvalid in; rready out
//  constants: Ax{LOCK,PROT,QOS,REGION}=0, AxCACHE=4'b0011, AxBURST=2'b01, WSTRB=all ones, user signals unused
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; FSM->IDLE; counters 0. Reset mid-burst aborts immediately (no drain).
//  FSM: IDLE -> (cmd_valid & cmd_ready) -> WR_ADDR or RD_ADDR; cmd_addr/len/rnw registered on accept.
//  WR_ADDR: awvalid=1 held with stable fields until awready; then WR_DATA.
//  WR_DATA: wvalid=wr_valid, wr_ready=wready (combinational pass-through, zero latency);
//   beat counter increments on wvalid&wready; wlast=1 when count==len; on last beat -> WR_RESP.
//  WR_RESP: bready=1; on bvalid capture bresp -> DONE.
//  RD_ADDR: arvalid=1 held until arready; then RD_DATA.
//  RD_DATA: rd_valid=rvalid, rready=rd_ready, rd_data=rdata, rd_last=rlast; RRESP error sticky;
//   on rvalid&rready&rlast -> DONE. Beat count mismatch vs len (rlast early/late) also sets err.
//  DONE: done=1, err=sticky flag for one cycle -> IDLE; error flag cleared on next accept.
//  No W before AW: wvalid never asserted before AW handshake completes.
//  Valid never deasserted without handshake (AXI rule); address fields stable while valid.
//  Latency: command accept -> awvalid/arvalid next cycle; done 1 cycle after B or last R.
//  cmd_len=0: single beat, wlast on first beat. Backpressure on any channel stalls FSM in place.
// CONFIGURATION
//  AXI_4K_CHECK_EN defined: on accept, if (addr[11:0] + (len+1)*DATA/8) > 4096 the command is
//   rejected: no AXI traffic, state goes IDLE->DONE, done=1, err=1 the cycle after accept.
//  Undefined: no check; burst is issued as given (caller guarantees legality).
// TESTING
//  1 write addr=0x1000 len=3, awready/wready/bvalid immediate -> 4 beats, wlast on beat 4, done=1 err=0.
//  2 read addr=0x2000 len=7, rvalid every other cycle, rd_ready=1 -> 8 beats out, rd_last on 8th, done err=0.
//  3 write len=0, awready delayed 5 cycles, BRESP=2'b10 -> awvalid held 6 cycles, no wvalid before AW, done err=1.
//  4 read len=3, rd_ready toggling, rlast on beat 3 -> rready follows rd_ready, done with err=1 (short burst).
//  5 assert reset during WR_DATA beat 2 -> all outputs 0 next edge, cmd_ready=1; next command runs cleanly.
//  6 AXI_4K_CHECK_EN: addr=0x0FC0 len=1 (512b) -> no awvalid, done=err=1; addr=0x0F80 len=1 -> normal burst.

Source files
------------

// File: rtl/axi4_burst_master_if.sv
// -----------------------------------------------------------------------------
// axi4_burst_master_if
// AXI4 bus bundle between axi4_burst_master and an AXI4 slave.
//   master modport : drives AW/W/AR channel payload + valid, B/R ready
//   slave  modport : drives AW/W/AR ready, B/R channel payload + valid
// Signals keep the m00_axi_* names of the bus they represent.
// User signals are not carried.
// -----------------------------------------------------------------------------
interface axi4_burst_master_if #(
  parameter int ID_W   = 1,
  parameter int DATA_W = 512,
  parameter int ADDR_W = 32
);
  // Write address channel
  logic [ID_W-1:0]     m00_axi_awid;
  logic [ADDR_W-1:0]   m00_axi_awaddr;
  logic [7:0]          m00_axi_awlen;
  logic [2:0]          m00_axi_awsize;
  logic [1:0]          m00_axi_awburst;
  logic                m00_axi_awlock;
  logic [3:0]          m00_axi_awcache;
  logic [2:0]          m00_axi_awprot;
  logic [3:0]          m00_axi_awqos;
  logic [3:0]          m00_axi_awregion;
  logic                m00_axi_awvalid;
  logic                m00_axi_awready;
  // Write data channel
  logic [DATA_W-1:0]   m00_axi_wdata;
  logic [DATA_W/8-1:0] m00_axi_wstrb;
  logic                m00_axi_wlast;
  logic                m00_axi_wvalid;
  logic                m00_axi_wready;
  // Write response channel
  logic [ID_W-1:0]     m00_axi_bid;
  logic [1:0]          m00_axi_bresp;
  logic                m00_axi_bvalid;
  logic                m00_axi_bready;
  // Read address channel
  logic [ID_W-1:0]     m00_axi_arid;
  logic [ADDR_W-1:0]   m00_axi_araddr;
  logic [7:0]          m00_axi_arlen;
  logic [2:0]          m00_axi_arsize;
  logic [1:0]          m00_axi_arburst;
  logic                m00_axi_arlock;
  logic [3:0]          m00_axi_arcache;
  logic [2:0]          m00_axi_arprot;
  logic [3:0]          m00_axi_arqos;
  logic [3:0]          m00_axi_arregion;
  logic                m00_axi_arvalid;
  logic                m00_axi_arready;
  // Read data channel
  logic [ID_W-1:0]     m00_axi_rid;
  logic [DATA_W-1:0]   m00_axi_rdata;
  logic [1:0]          m00_axi_rresp;
  logic                m00_axi_rlast;
  logic                m00_axi_rvalid;
  logic                m00_axi_rready;

  modport master (
    output m00_axi_awid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
           m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos, m00_axi_awregion,
           m00_axi_awvalid,
    input  m00_axi_awready,
    output m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast, m00_axi_wvalid,
    input  m00_axi_wready,
    input  m00_axi_bid, m00_axi_bresp, m00_axi_bvalid,
    output m00_axi_bready,
    output m00_axi_arid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
           m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos, m00_axi_arregion,
           m00_axi_arvalid,
    input  m00_axi_arready,
    input  m00_axi_rid, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
    output m00_axi_rready
  );

  modport slave (
    input  m00_axi_awid, m00_axi_awaddr, m00_axi_awlen, m00_axi_awsize, m00_axi_awburst,
           m00_axi_awlock, m00_axi_awcache, m00_axi_awprot, m00_axi_awqos, m00_axi_awregion,
           m00_axi_awvalid,
    output m00_axi_awready,
    input  m00_axi_wdata, m00_axi_wstrb, m00_axi_wlast, m00_axi_wvalid,
    output m00_axi_wready,
    output m00_axi_bid, m00_axi_bresp, m00_axi_bvalid,
    input  m00_axi_bready,
    input  m00_axi_arid, m00_axi_araddr, m00_axi_arlen, m00_axi_arsize, m00_axi_arburst,
           m00_axi_arlock, m00_axi_arcache, m00_axi_arprot, m00_axi_arqos, m00_axi_arregion,
           m00_axi_arvalid,
    output m00_axi_arready,
    output m00_axi_rid, m00_axi_rdata, m00_axi_rresp, m00_axi_rlast, m00_axi_rvalid,
    input  m00_axi_rready
  );
endinterface

// File: rtl/axi4_burst_master.sv
// -----------------------------------------------------------------------------
// axi4_burst_master
// Single-outstanding AXI4 master: one local command becomes one INCR burst.
//
// Ports
//   m00_axi_aclk, m00_axi_aresetn : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           : command handshake (ready only in IDLE)
//   cmd_rnw, cmd_addr, cmd_len    : 1=read; beat-aligned byte address; beats-1
//   wr_data/wr_valid/wr_ready     : write payload stream (into the master)
//   rd_data/rd_valid/rd_ready/rd_last : read payload stream (out of the master)
//   done, err                     : one-cycle completion pulse, error valid with done
//   dbg_state                     : current FSM state encoding (state_t)
//   m00_axi                       : AXI4 bus, master modport
//
// Handshakes: every valid/ready pair transfers on a rising edge where both are
// high. A valid, once raised, stays high with stable payload until that edge;
// ready may depend combinationally on valid. The local write stream maps onto
// W with zero latency, and R maps onto the local read stream the same way.
//
// Optional feature: define AXI_4K_CHECK_EN to reject commands whose burst
// would cross a 4 KiB boundary (done=err=1 the cycle after accept, no bus
// traffic). Undefined, bursts are issued exactly as commanded.
// -----------------------------------------------------------------------------
module axi4_burst_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 32
) (
  input  logic                          m00_axi_aclk,
  input  logic                          m00_axi_aresetn,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]                    cmd_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0] rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          rd_last,
  output logic                          done,
  output logic                          err,
  output logic [2:0]                    dbg_state,
  axi4_burst_master_if.master           m00_axi
);

  localparam int         BYTES  = C_M_AXI_DATA_WIDTH / 8;
  localparam logic [2:0] AXSIZE = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t                        state_q, state_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]                    len_q, len_d;
  logic [7:0]                    cnt_q, cnt_d;
  logic                          err_q, err_d;
  logic                          cross_4k;

  assign dbg_state = state_q;

`ifdef AXI_4K_CHECK_EN
  // Last byte + 1 of the burst relative to the 4 KiB page start.
  logic [31:0] span_end;
  assign span_end = 32'(cmd_addr[11:0]) + ((32'(cmd_len) + 32'd1) * 32'(BYTES));
  assign cross_4k = (span_end > 32'd4096);
`else
  assign cross_4k = 1'b0;
`endif

  // IDs are always zero; fold the returned IDs away explicitly.
  logic unused_ids;
  assign unused_ids = ^{m00_axi.m00_axi_bid, m00_axi.m00_axi_rid};

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    cmd_ready = 1'b0;
    wr_ready  = 1'b0;
    rd_data   = '0;
    rd_valid  = 1'b0;
    rd_last   = 1'b0;
    done      = 1'b0;
    err       = 1'b0;

    m00_axi.m00_axi_awid     = '0;
    m00_axi.m00_axi_awaddr   = '0;
    m00_axi.m00_axi_awlen    = '0;
    m00_axi.m00_axi_awsize   = '0;
    m00_axi.m00_axi_awburst  = '0;
    m00_axi.m00_axi_awlock   = 1'b0;
    m00_axi.m00_axi_awcache  = '0;
    m00_axi.m00_axi_awprot   = '0;
    m00_axi.m00_axi_awqos    = '0;
    m00_axi.m00_axi_awregion = '0;
    m00_axi.m00_axi_awvalid  = 1'b0;
    m00_axi.m00_axi_wdata    = '0;
    m00_axi.m00_axi_wstrb    = '0;
    m00_axi.m00_axi_wlast    = 1'b0;
    m00_axi.m00_axi_wvalid   = 1'b0;
    m00_axi.m00_axi_bready   = 1'b0;
    m00_axi.m00_axi_arid     = '0;
    m00_axi.m00_axi_araddr   = '0;
    m00_axi.m00_axi_arlen    = '0;
    m00_axi.m00_axi_arsize   = '0;
    m00_axi.m00_axi_arburst  = '0;
    m00_axi.m00_axi_arlock   = 1'b0;
    m00_axi.m00_axi_arcache  = '0;
    m00_axi.m00_axi_arprot   = '0;
    m00_axi.m00_axi_arqos    = '0;
    m00_axi.m00_axi_arregion = '0;
    m00_axi.m00_axi_arvalid  = 1'b0;
    m00_axi.m00_axi_rready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          addr_d = cmd_addr;
          len_d  = cmd_len;
          cnt_d  = '0;
          err_d  = 1'b0;
          if (cross_4k) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = cmd_rnw ? S_RD_ADDR : S_WR_ADDR;
          end
        end
      end

      // Address fields come from registers captured on accept, so they stay
      // stable for as long as awvalid is held.
      S_WR_ADDR: begin
        m00_axi.m00_axi_awaddr  = addr_q;
        m00_axi.m00_axi_awlen   = len_q;
        m00_axi.m00_axi_awsize  = AXSIZE;
        m00_axi.m00_axi_awburst = 2'b01;
        m00_axi.m00_axi_awcache = 4'b0011;
        m00_axi.m00_axi_awvalid = 1'b1;
        if (m00_axi.m00_axi_awready) state_d = S_WR_DATA;
      end

      // W is only reachable after the AW handshake, so wvalid can never lead AW.
      S_WR_DATA: begin
        m00_axi.m00_axi_wdata  = wr_data;
        m00_axi.m00_axi_wstrb  = '1;
        m00_axi.m00_axi_wvalid = wr_valid;
        m00_axi.m00_axi_wlast  = (cnt_q == len_q);
        wr_ready               = m00_axi.m00_axi_wready;
        if (wr_valid && m00_axi.m00_axi_wready) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == len_q) state_d = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        m00_axi.m00_axi_bready = 1'b1;
        if (m00_axi.m00_axi_bvalid) begin
          err_d   = err_q | (m00_axi.m00_axi_bresp != 2'b00);
          state_d = S_DONE;
        end
      end

      S_RD_ADDR: begin
        m00_axi.m00_axi_araddr  = addr_q;
        m00_axi.m00_axi_arlen   = len_q;
        m00_axi.m00_axi_arsize  = AXSIZE;
        m00_axi.m00_axi_arburst = 2'b01;
        m00_axi.m00_axi_arcache = 4'b0011;
        m00_axi.m00_axi_arvalid = 1'b1;
        if (m00_axi.m00_axi_arready) state_d = S_RD_DATA;
      end

      // The burst ends on rlast whatever the beat count; an rlast before beat
      // len, or a missing rlast on beat len, is reported as an error.
      S_RD_DATA: begin
        rd_data                = m00_axi.m00_axi_rdata;
        rd_valid               = m00_axi.m00_axi_rvalid;
        rd_last                = m00_axi.m00_axi_rlast;
        m00_axi.m00_axi_rready = rd_ready;
        if (m00_axi.m00_axi_rvalid && rd_ready) begin
          cnt_d = cnt_q + 8'd1;
          err_d = err_q
                | (m00_axi.m00_axi_rresp != 2'b00)
                | (m00_axi.m00_axi_rlast && (cnt_q != len_q))
                | (!m00_axi.m00_axi_rlast && (cnt_q == len_q));
          if (m00_axi.m00_axi_rlast) state_d = S_DONE;
        end
      end

      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
module tb_axi4_burst_master;

  localparam int DW      = 512;
  localparam int AW      = 32;
  localparam int MAX_CYC = 80;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_rnw;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wr_data;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          rd_last;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axi4_burst_master_if #(.ID_W(1), .DATA_W(DW), .ADDR_W(AW)) axi ();

  axi4_burst_master #(
    .C_M_AXI_ID_WIDTH  (1),
    .C_M_AXI_DATA_WIDTH(DW),
    .C_M_AXI_ADDR_WIDTH(AW)
  ) dut (
    .m00_axi_aclk   (clk),
    .m00_axi_aresetn(rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rnw        (cmd_rnw),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .rd_last        (rd_last),
    .done           (done),
    .err            (err),
    .dbg_state      (dbg_state),
    .m00_axi        (axi)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- observation record filled by the driver tasks ----------------
  int          obs_aw_cycles;
  int          obs_ar_cycles;
  int          obs_beats;
  int          obs_last_beat;
  int          obs_early_w;
  int          obs_bad_data;
  int          obs_bad_pass;
  int          obs_unstable;
  int          obs_done_cyc;
  int          obs_hs_cyc;
  bit          obs_done;
  logic        obs_err;
  logic [31:0] obs_addr;
  logic [7:0]  obs_len;
  logic [2:0]  obs_size;
  logic [1:0]  obs_burst;
  logic [3:0]  obs_cache;

  function automatic logic [DW-1:0] pattern(input int b, input int salt);
    logic [31:0] w;
    w = 32'hC0DE0000 ^ 32'(salt << 8) ^ 32'(b);
    return {16{w}};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    cmd_valid = 1'b0;
    cmd_rnw   = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_data   = '0;
    wr_valid  = 1'b0;
    rd_ready  = 1'b0;
    axi.m00_axi_awready = 1'b0;
    axi.m00_axi_wready  = 1'b0;
    axi.m00_axi_bid     = '0;
    axi.m00_axi_bresp   = 2'b00;
    axi.m00_axi_bvalid  = 1'b0;
    axi.m00_axi_arready = 1'b0;
    axi.m00_axi_rid     = '0;
    axi.m00_axi_rdata   = '0;
    axi.m00_axi_rresp   = 2'b00;
    axi.m00_axi_rlast   = 1'b0;
    axi.m00_axi_rvalid  = 1'b0;
  endtask

  task automatic clear_obs();
    obs_aw_cycles = 0; obs_ar_cycles = 0; obs_beats = 0; obs_last_beat = -1;
    obs_early_w = 0; obs_bad_data = 0; obs_bad_pass = 0; obs_unstable = 0;
    obs_done_cyc = -1; obs_hs_cyc = -1; obs_done = 0; obs_err = 1'bx;
    obs_addr = '0; obs_len = '0; obs_size = '0; obs_burst = '0; obs_cache = '0;
  endtask

  // Entered and left at posedge+1; the command is accepted at the edge inside.
  task automatic send_cmd(input logic rnw, input logic [31:0] addr, input logic [7:0] len);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = addr;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Reactive write slave plus local write source; bvalid only after wlast.
  task automatic run_write(input int aw_delay, input logic [1:0] bresp_v, input int salt);
    bit aw_done;
    bit w_done;
    clear_obs();
    aw_done = 0;
    w_done  = 0;
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      axi.m00_axi_awready = (obs_aw_cycles >= aw_delay);
      axi.m00_axi_wready  = 1'b1;
      wr_valid            = 1'b1;
      wr_data             = pattern(obs_beats, salt);
      axi.m00_axi_bvalid  = w_done;
      axi.m00_axi_bresp   = w_done ? bresp_v : 2'b00;
      @(negedge clk);
      if (axi.m00_axi_wvalid && !aw_done) obs_early_w++;
      if (axi.m00_axi_awvalid) begin
        if (obs_aw_cycles == 0) begin
          obs_addr  = axi.m00_axi_awaddr;
          obs_len   = axi.m00_axi_awlen;
          obs_size  = axi.m00_axi_awsize;
          obs_burst = axi.m00_axi_awburst;
          obs_cache = axi.m00_axi_awcache;
        end else if (axi.m00_axi_awaddr !== obs_addr || axi.m00_axi_awlen !== obs_len) begin
          obs_unstable++;
        end
        obs_aw_cycles++;
        if (axi.m00_axi_awready) aw_done = 1;
      end
      if (axi.m00_axi_wvalid && axi.m00_axi_wready) begin
        if (axi.m00_axi_wdata !== pattern(obs_beats, salt)) obs_bad_data++;
        if (wr_ready !== 1'b1) obs_bad_pass++;
        if (axi.m00_axi_wlast) begin
          obs_last_beat = obs_beats;
          w_done = 1;
        end
        obs_beats++;
      end
      if (axi.m00_axi_bvalid && axi.m00_axi_bready) begin
        obs_hs_cyc = cyc;
        w_done = 0;
      end
      if (done) begin
        obs_done     = 1;
        obs_err      = err;
        obs_done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (obs_done) break;
    end
    idle_inputs();
  endtask

  // Reactive read slave plus local read sink; rlast on beat rlast_idx.
  task automatic run_read(input bit every_other, input bit toggle_ready,
                          input int rlast_idx, input int salt);
    bit ar_done;
    bit pend;
    int sent;
    clear_obs();
    ar_done = 0;
    pend    = 0;
    sent    = 0;
    for (int cyc = 0; cyc < MAX_CYC; cyc++) begin
      rd_ready            = toggle_ready ? (cyc % 2 == 1) : 1'b1;
      axi.m00_axi_arready = 1'b1;
      axi.m00_axi_rvalid  = ar_done && (sent <= rlast_idx) &&
                            (pend || !every_other || (cyc % 2 == 0));
      axi.m00_axi_rdata   = pattern(sent, salt);
      axi.m00_axi_rlast   = (sent == rlast_idx);
      axi.m00_axi_rresp   = 2'b00;
      @(negedge clk);
      if (axi.m00_axi_arvalid) begin
        if (obs_ar_cycles == 0) begin
          obs_addr  = axi.m00_axi_araddr;
          obs_len   = axi.m00_axi_arlen;
          obs_size  = axi.m00_axi_arsize;
          obs_burst = axi.m00_axi_arburst;
          obs_cache = axi.m00_axi_arcache;
        end
        obs_ar_cycles++;
        if (axi.m00_axi_arready) ar_done = 1;
      end
      if (axi.m00_axi_rvalid) begin
        if (axi.m00_axi_rready !== rd_ready || rd_valid !== 1'b1) obs_bad_pass++;
        if (axi.m00_axi_rready) begin
          if (rd_data !== pattern(sent, salt)) obs_bad_data++;
          if (rd_last) obs_last_beat = sent;
          obs_beats++;
          sent++;
          obs_hs_cyc = cyc;
          pend = 0;
        end else begin
          pend = 1;
        end
      end
      if (done) begin
        obs_done     = 1;
        obs_err      = err;
        obs_done_cyc = cyc;
      end
      @(posedge clk); #1;
      if (obs_done) break;
    end
    idle_inputs();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); else pass_cnt++;
    total_cnt++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
    total_cnt++; if ({axi.m00_axi_awvalid, axi.m00_axi_wvalid, axi.m00_axi_bready, axi.m00_axi_arvalid, axi.m00_axi_rready} !== 5'b0)
      $display("FAIL reset_axi_valids: got %b want 00000", {axi.m00_axi_awvalid, axi.m00_axi_wvalid, axi.m00_axi_bready, axi.m00_axi_arvalid, axi.m00_axi_rready}); else pass_cnt++;
    total_cnt++; if ({done, err, wr_ready, rd_valid, rd_last} !== 5'b0)
      $display("FAIL reset_local_outs: got %b want 00000", {done, err, wr_ready, rd_valid, rd_last}); else pass_cnt++;
    total_cnt++; if (axi.m00_axi_awsize !== 3'd0 || axi.m00_axi_awaddr !== 32'd0)
      $display("FAIL reset_aw_fields: got size %0d addr %0h want 0 0", axi.m00_axi_awsize, axi.m00_axi_awaddr); else pass_cnt++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_basic();
    send_cmd(1'b0, 32'h0000_1000, 8'd3);
    run_write(0, 2'b00, 1);
    total_cnt++; if (obs_addr !== 32'h1000) $display("FAIL wr1_awaddr: got %0h want 1000", obs_addr); else pass_cnt++;
    total_cnt++; if (obs_len !== 8'd3) $display("FAIL wr1_awlen: got %0d want 3", obs_len); else pass_cnt++;
    total_cnt++; if ({obs_size, obs_burst, obs_cache} !== {3'd6, 2'b01, 4'b0011})
      $display("FAIL wr1_aw_consts: got size %0d burst %0d cache %0h want 6 1 3", obs_size, obs_burst, obs_cache); else pass_cnt++;
    total_cnt++; if (obs_aw_cycles !== 1) $display("FAIL wr1_aw_cycles: got %0d want 1", obs_aw_cycles); else pass_cnt++;
    total_cnt++; if (obs_beats !== 4) $display("FAIL wr1_beats: got %0d want 4", obs_beats); else pass_cnt++;
    total_cnt++; if (obs_last_beat !== 3) $display("FAIL wr1_wlast_beat: got %0d want 3", obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_bad_data !== 0 || obs_bad_pass !== 0)
      $display("FAIL wr1_wdata: got %0d/%0d bad want 0/0", obs_bad_data, obs_bad_pass); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b0)
      $display("FAIL wr1_done_err: got done %0b err %0b want 1 0", obs_done, obs_err); else pass_cnt++;
    total_cnt++; if (obs_done_cyc !== obs_hs_cyc + 1)
      $display("FAIL wr1_done_latency: got cycle %0d want %0d", obs_done_cyc, obs_hs_cyc + 1); else pass_cnt++;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1 || done !== 1'b0)
      $display("FAIL wr1_back_idle: got ready %0b done %0b want 1 0", cmd_ready, done); else pass_cnt++;
  endtask

  task automatic test_read_basic();
    send_cmd(1'b1, 32'h0000_2000, 8'd7);
    run_read(1'b1, 1'b0, 7, 2);
    total_cnt++; if (obs_addr !== 32'h2000 || obs_len !== 8'd7)
      $display("FAIL rd2_ar_fields: got %0h/%0d want 2000/7", obs_addr, obs_len); else pass_cnt++;
    total_cnt++; if (obs_ar_cycles !== 1) $display("FAIL rd2_ar_cycles: got %0d want 1", obs_ar_cycles); else pass_cnt++;
    total_cnt++; if (obs_beats !== 8) $display("FAIL rd2_beats: got %0d want 8", obs_beats); else pass_cnt++;
    total_cnt++; if (obs_last_beat !== 7) $display("FAIL rd2_rd_last_beat: got %0d want 7", obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_bad_data !== 0 || obs_bad_pass !== 0)
      $display("FAIL rd2_rd_data: got %0d/%0d bad want 0/0", obs_bad_data, obs_bad_pass); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b0)
      $display("FAIL rd2_done_err: got done %0b err %0b want 1 0", obs_done, obs_err); else pass_cnt++;
    total_cnt++; if (obs_done_cyc !== obs_hs_cyc + 1)
      $display("FAIL rd2_done_latency: got cycle %0d want %0d", obs_done_cyc, obs_hs_cyc + 1); else pass_cnt++;
  endtask

  task automatic test_write_stall_bresp();
    send_cmd(1'b0, 32'h0000_4040, 8'd0);
    run_write(5, 2'b10, 3);
    total_cnt++; if (obs_aw_cycles !== 6) $display("FAIL wr3_aw_held: got %0d want 6", obs_aw_cycles); else pass_cnt++;
    total_cnt++; if (obs_unstable !== 0) $display("FAIL wr3_aw_stable: got %0d changes want 0", obs_unstable); else pass_cnt++;
    total_cnt++; if (obs_early_w !== 0) $display("FAIL wr3_w_before_aw: got %0d want 0", obs_early_w); else pass_cnt++;
    total_cnt++; if (obs_beats !== 1 || obs_last_beat !== 0)
      $display("FAIL wr3_single_beat: got beats %0d last %0d want 1 0", obs_beats, obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b1)
      $display("FAIL wr3_done_err: got done %0b err %0b want 1 1", obs_done, obs_err); else pass_cnt++;
  endtask

  task automatic test_read_short_burst();
    send_cmd(1'b1, 32'h0000_3000, 8'd3);
    run_read(1'b0, 1'b1, 2, 4);
    total_cnt++; if (obs_bad_pass !== 0) $display("FAIL rd4_rready_follow: got %0d bad want 0", obs_bad_pass); else pass_cnt++;
    total_cnt++; if (obs_beats !== 3 || obs_last_beat !== 2)
      $display("FAIL rd4_beats: got beats %0d last %0d want 3 2", obs_beats, obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_bad_data !== 0) $display("FAIL rd4_rd_data: got %0d bad want 0", obs_bad_data); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b1)
      $display("FAIL rd4_done_err: got done %0b err %0b want 1 1", obs_done, obs_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid_burst();
    send_cmd(1'b0, 32'h0000_5000, 8'd3);
    axi.m00_axi_awready = 1'b1;
    axi.m00_axi_wready  = 1'b1;
    wr_valid            = 1'b1;
    @(posedge clk); #1;   // AW done, first W beat now offered
    @(posedge clk); #1;   // first beat taken, second beat in progress
    total_cnt++; if (dbg_state !== 3'd2) $display("FAIL rst5_in_wr_data: got %0d want 2", dbg_state); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({axi.m00_axi_awvalid, axi.m00_axi_wvalid, axi.m00_axi_wlast, axi.m00_axi_bready, wr_ready, done, err} !== 7'b0)
      $display("FAIL rst5_outputs_zero: got %b want 0000000", {axi.m00_axi_awvalid, axi.m00_axi_wvalid, axi.m00_axi_wlast, axi.m00_axi_bready, wr_ready, done, err}); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1 || dbg_state !== 3'd0)
      $display("FAIL rst5_idle: got ready %0b state %0d want 1 0", cmd_ready, dbg_state); else pass_cnt++;
    idle_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_cmd(1'b0, 32'h0000_6000, 8'd3);
    run_write(0, 2'b00, 5);
    total_cnt++; if (obs_addr !== 32'h6000 || obs_beats !== 4 || obs_last_beat !== 3)
      $display("FAIL rst5_rerun: got addr %0h beats %0d last %0d want 6000 4 3", obs_addr, obs_beats, obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b0)
      $display("FAIL rst5_rerun_done: got done %0b err %0b want 1 0", obs_done, obs_err); else pass_cnt++;
  endtask

`ifdef AXI_4K_CHECK_EN
  task automatic test_4k_boundary();
    int aw_seen;
    aw_seen = 0;
    send_cmd(1'b0, 32'h0000_0FC0, 8'd1);
    @(negedge clk);
    total_cnt++; if (done !== 1'b1 || err !== 1'b1)
      $display("FAIL k6_reject: got done %0b err %0b want 1 1", done, err); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      if (axi.m00_axi_awvalid || axi.m00_axi_wvalid) aw_seen++;
      @(negedge clk);
    end
    total_cnt++; if (aw_seen !== 0) $display("FAIL k6_no_traffic: got %0d want 0", aw_seen); else pass_cnt++;
    @(posedge clk); #1;
    send_cmd(1'b0, 32'h0000_0F80, 8'd1);
    run_write(0, 2'b00, 6);
    total_cnt++; if (obs_aw_cycles !== 1 || obs_beats !== 2 || obs_last_beat !== 1)
      $display("FAIL k6_edge_burst: got aw %0d beats %0d last %0d want 1 2 1", obs_aw_cycles, obs_beats, obs_last_beat); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b0)
      $display("FAIL k6_edge_done: got done %0b err %0b want 1 0", obs_done, obs_err); else pass_cnt++;
  endtask
`else
  task automatic test_4k_boundary();
    send_cmd(1'b0, 32'h0000_0FC0, 8'd1);
    run_write(0, 2'b00, 6);
    total_cnt++; if (obs_aw_cycles !== 1 || obs_addr !== 32'h0FC0 || obs_beats !== 2)
      $display("FAIL k6_unchecked_burst: got aw %0d addr %0h beats %0d want 1 fc0 2", obs_aw_cycles, obs_addr, obs_beats); else pass_cnt++;
    total_cnt++; if (obs_done !== 1'b1 || obs_err !== 1'b0)
      $display("FAIL k6_unchecked_done: got done %0b err %0b want 1 0", obs_done, obs_err); else pass_cnt++;
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_stall_bresp();
    test_read_short_burst();
    test_reset_mid_burst();
    test_4k_boundary();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
